// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline-control types, constants and the load-use hazard check
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BR_FLUSH = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int DEF_FLUSH_CYCLES = 1;
    localparam int DEF_MEM_TIMEOUT = 64;

    // $zero is never a real producer, so a load targeting it cannot create a hazard
    function automatic logic load_use(
        input logic       rden,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       uses_rt
    );
        return rden && ex_rt != REG_ZERO && (ex_rt == id_rs || (uses_rt && ex_rt == id_rt));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
//   clock  in   clock
//   clear  in   synchronous clear to zero (wins over inc)
//   inc    in   count up by one, holding at all-ones
//   count  out  current value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock)
        count <= clear ? '0 : (inc && !(&count)) ? count + W'(1) : count;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / branch-flush / memory-wait sequencing for the 5-stage pipeline
//   clock, reset                   clock and synchronous active-high reset
//   ID_RS, ID_RT, ID_UsesRT        source registers of the instruction in ID
//   EX_MEM_RDEN, EX_RT             load in EX and its destination
//   branch_taken                   EX redirects the PC
//   mem_busy                       data memory not ready
//   PC_Write, IFID_Write           PC and IF_ID enables (combinational)
//   IFID_Flush, IDEX_Flush         bubble insertion (combinational)
//   Pipe_Hold                      freeze EX_MEM and MEM_WB (combinational)
//   stall_cnt, flush_cnt, wait_cnt saturating statistics
//   mem_timeout                    sticky memory-wait watchdog
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int MEM_TIMEOUT  = DEF_MEM_TIMEOUT,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       ID_RS,
    input  logic [4:0]       ID_RT,
    input  logic             ID_UsesRT,
    input  logic             EX_MEM_RDEN,
    input  logic [4:0]       EX_RT,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             Pipe_Hold,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt,
    output logic             mem_timeout
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    state_t        state, saved_state, eff_state;
    logic [1:0]    flush_left, saved_left, eff_left;
    logic [TW-1:0] wait_timer;
    logic          do_flush, do_stall;

    // When a memory wait ends, the interrupted state takes effect in the same cycle
    always_comb begin
        eff_state  = (state == MEM_WAIT) ? saved_state : state;
        eff_left   = (state == MEM_WAIT) ? saved_left : flush_left;
        do_flush   = !mem_busy && (eff_state == BR_FLUSH || (eff_state == RUN && branch_taken));
        do_stall   = !mem_busy && eff_state == RUN && !branch_taken &&
                     load_use(EX_MEM_RDEN, EX_RT, ID_RS, ID_RT, ID_UsesRT);
        PC_Write   = !reset && !mem_busy && !do_stall;
        IFID_Write = !reset && !mem_busy && !do_stall;
        IFID_Flush = reset || do_flush;
        IDEX_Flush = reset || do_flush || do_stall;
        Pipe_Hold  = !reset && mem_busy;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= RUN;
            flush_left  <= '0;
            saved_state <= RUN;
            saved_left  <= '0;
            wait_timer  <= '0;
            mem_timeout <= 1'b0;
        end else if (mem_busy) begin
            state <= MEM_WAIT;
            if (state != MEM_WAIT) begin
                saved_state <= state;
                saved_left  <= flush_left;
            end
            if (wait_timer != TW'(MEM_TIMEOUT))
                wait_timer <= wait_timer + TW'(1);
            if (wait_timer >= TW'(MEM_TIMEOUT - 1))
                mem_timeout <= 1'b1;
        end else begin
            wait_timer <= '0;
            if (eff_state == BR_FLUSH) begin
                state      <= (eff_left == 2'd1) ? RUN : BR_FLUSH;
                flush_left <= eff_left - 2'd1;
            end else if (branch_taken && FLUSH_CYCLES > 1) begin
                state      <= BR_FLUSH;
                flush_left <= 2'(FLUSH_CYCLES - 1);
            end else begin
                state      <= RUN;
                flush_left <= '0;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall (.clock(clock), .clear(reset), .inc(do_stall), .count(stall_cnt));
    sat_counter #(.W(CNT_W)) u_flush (.clock(clock), .clear(reset), .inc(do_flush), .count(flush_cnt));
    sat_counter #(.W(CNT_W)) u_wait  (.clock(clock), .clear(reset), .inc(!reset && mem_busy), .count(wait_cnt));

endmodule
